nonce_recorder: RTL

Downstream stage of the mining pipeline. It consumes the per-nonce result stream from the hash/validator stage: one `result_valid` beat per nonce tried, with `new_block` marking the first nonce of a block and `success` marking a winning hash. It reconstructs the nonce value of each beat and queues every winning nonce, tagged with a block sequence number, in a small FIFO. The host drains the FIFO through a valid/ready read port; drops on a full FIFO are reported by a sticky overflow flag.

---
 rtl/miner_pkg.sv | 9 +
 rtl/nonce_recorder_if.sv | 25 ++
 rtl/nonce_fifo.sv | 47 ++++
 rtl/nonce_recorder.sv | 52 +++++
 4 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: shared types and default widths for the mining pipeline.
package miner_pkg;
  localparam int DEF_NONCE_BITS = 32;
  localparam int DEF_TAG_BITS = 4;
  typedef struct packed {
    logic [DEF_TAG_BITS-1:0] tag;
    logic [DEF_NONCE_BITS-1:0] nonce;
  } nonce_entry_t;
endpackage

// File: rtl/nonce_recorder_if.sv
// nonce_recorder_if: result stream input and host read port of the nonce recorder.
interface nonce_recorder_if import miner_pkg::*; #(
  parameter int NONCE_BITS = DEF_NONCE_BITS,
  parameter int TAG_BITS = DEF_TAG_BITS,
  parameter int LOGDEPTH = 3
);
  logic result_valid;
  logic new_block;
  logic success;
  logic rd_ready;
  logic rd_valid;
  logic [NONCE_BITS-1:0] rd_nonce;
  logic [TAG_BITS-1:0] rd_tag;
  logic [LOGDEPTH:0] count;
  logic overflow;
  logic clr_overflow;
  modport slave(
    input result_valid, new_block, success, rd_ready, clr_overflow,
    output rd_valid, rd_nonce, rd_tag, count, overflow
  );
  modport master(
    output result_valid, new_block, success, rd_ready, clr_overflow,
    input rd_valid, rd_nonce, rd_tag, count, overflow
  );
endinterface

// File: rtl/nonce_fifo.sv
// nonce_fifo: synchronous FIFO with a registered head entry and occupancy count.
module nonce_fifo import miner_pkg::*; #(
  parameter type T = nonce_entry_t,
  parameter int LOGDEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic wr,
  input  logic rd,
  input  T din,
  output T head,
  output logic [LOGDEPTH:0] count,
  output logic full,
  output logic empty
);
  localparam int DEPTH = 1 << LOGDEPTH;
  T mem [DEPTH];
  T head_n;
  logic [LOGDEPTH-1:0] wptr, rptr;
  logic [LOGDEPTH:0] count_n;
  logic do_wr, do_rd;
  assign full = count == (LOGDEPTH+1)'(DEPTH);
  assign empty = count == '0;
  always_comb begin
    do_rd = rd & ~empty;
    do_wr = wr & (~full | do_rd);
    count_n = count + (LOGDEPTH+1)'(do_wr) - (LOGDEPTH+1)'(do_rd);
    // a lone remaining entry being popped is replaced by the word written this cycle
    head_n = do_rd ? (count == (LOGDEPTH+1)'(1) ? din : mem[rptr + 1'b1])
                   : (empty && do_wr ? din : head);
  end
  always_ff @(posedge clk)
    if (do_wr) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      head <= '0;
    end else begin
      wptr <= do_wr ? wptr + 1'b1 : wptr;
      rptr <= do_rd ? rptr + 1'b1 : rptr;
      count <= count_n;
      head <= head_n;
    end
  end
endmodule

// File: rtl/nonce_recorder.sv
// nonce_recorder: rebuilds per-beat nonces and queues winning nonces tagged by block.
module nonce_recorder import miner_pkg::*; #(
  parameter int NONCE_BITS = DEF_NONCE_BITS,
  parameter int TAG_BITS = DEF_TAG_BITS,
  parameter int LOGDEPTH = 3
) (
  input logic clk,
  input logic rst,
  nonce_recorder_if.slave bus
);
  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [NONCE_BITS-1:0] nonce;
  } entry_t;
  entry_t din, head;
  logic [NONCE_BITS-1:0] cur_nonce, beat_nonce;
  logic [TAG_BITS-1:0] tag, next_tag;
  logic push, drop, full, empty, overflow;
  always_comb begin
    beat_nonce = bus.new_block ? '0 : cur_nonce + 1'b1;
    next_tag = bus.new_block ? tag + 1'b1 : tag;
    push = bus.result_valid & bus.success;
    drop = push & full & ~(bus.rd_ready & ~empty);
    din = '{tag: next_tag, nonce: beat_nonce};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_nonce <= '1;
      tag <= '0;
      overflow <= 1'b0;
    end else begin
      cur_nonce <= bus.result_valid ? beat_nonce : cur_nonce;
      tag <= bus.result_valid ? next_tag : tag;
      overflow <= drop | (overflow & ~bus.clr_overflow);
    end
  end
  nonce_fifo #(.T(entry_t), .LOGDEPTH(LOGDEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .wr(push),
    .rd(bus.rd_ready),
    .din(din),
    .head(head),
    .count(bus.count),
    .full(full),
    .empty(empty)
  );
  assign bus.rd_valid = ~empty;
  assign bus.rd_nonce = head.nonce;
  assign bus.rd_tag = head.tag;
  assign bus.overflow = overflow;
endmodule
